pong_ball_engine: RTL and testbench
===================================

PONG_BALL_ENGINE -- requirements
Module: pong_ball_engine

Interface
REQ-001 The module SHALL take parameters: H_ACTIVE 640, visible columns; V_ACTIVE 480, visible rows; PAD_HALF 24, paddle half-height in rows; LP_COL 64, left paddle face column; RP_COL 576, right paddle face column; DX0 2, serve horizontal speed; DX_MAX 8, horizontal speed ceiling; WIN_SCORE 9, points to win the match.
REQ-002 CLOCK_50  in  1  system clock; all state changes occur on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 frame_tick  in  1  one-cycle pulse, once per video frame; ball motion steps only on it.
REQ-005 serve  in  1  serve request, sampled every cycle.
REQ-006 lp_row, rp_row  in  9 each  paddle centre rows.
REQ-007 ball_row  out  9  ball centre row; ball_col  out  10  ball centre column.
REQ-008 left_score, right_score  out  4 each  match scores.
REQ-009 point_l, point_r  out  1 each  one-cycle pulse when left or right wins a point.
REQ-010 game_over  out  1  high while the match is finished; state  out  2  FSM state code.

Function
REQ-011 FSM states SHALL be: WAIT=0 (ball parked), PLAY=1, POINT=2 (one cycle), OVER=3.
REQ-012 WAIT: on serve -> PLAY next cycle; frame_tick in that cycle causes no motion.
REQ-013 PLAY, on frame_tick only, per-axis evaluation order SHALL be paddle hit, miss, normal move.
REQ-014 Left hit: dir left, col-dx <= LP_COL, col > LP_COL, and lp_row-PAD_HALF <= row <= lp_row+PAD_HALF (10-bit signed compare, no wrap) -> col := LP_COL, dir := right, dx := min(dx+1, DX_MAX).
REQ-015 Right hit mirrors REQ-014: col+dx >= RP_COL, col < RP_COL -> col := RP_COL, dir := left.
REQ-016 Miss: dir left and col <= dx -> right scores; dir right and col+dx >= H_ACTIVE-1 -> left scores; FSM -> POINT; ball holds position.
REQ-017 Normal horizontal move: col := col +/- dx.
REQ-018 Vertical: row := row +/- 1 on every PLAY tick, including hit ticks; when the new row equals 0 or V_ACTIVE-1, dy direction SHALL flip for the next tick.
REQ-019 POINT (one cycle): scorer's score +1; matching point_l/point_r high for exactly this cycle; FSM -> OVER if the new score == WIN_SCORE, else -> WAIT.
REQ-020 On entering WAIT from POINT: ball := (H_ACTIVE/2, V_ACTIVE/2), dx := DX0, dy := down (row increasing), dir := toward the player who lost the point.
REQ-021 OVER: game_over=1; ball parked at centre; frame_tick ignored; serve -> scores := 0, dir := right, FSM -> WAIT.
REQ-022 frame_tick in POINT, WAIT, or OVER SHALL produce no motion.
REQ-023 Scores SHALL never exceed WIN_SCORE; no wrap.
REQ-024 Outputs SHALL be registered; ball position changes one cycle after the qualifying frame_tick.

Reset
REQ-025 reset SHALL take priority over all inputs in any state.
REQ-026 Reset values: state WAIT, ball (H_ACTIVE/2, V_ACTIVE/2), dx DX0, dir right, dy down, scores 0, point_l/point_r 0, game_over 0.

Verification
REQ-027 Reset, serve, 1 frame_tick -> ball (row 241, col 322), state PLAY.
REQ-028 Serve, rp_row=0, 160 ticks -> miss at col 638; point_l pulses 1 cycle; left_score=1; ball (240, 320); WAIT; dir right.
REQ-029 Serve, rp_row=367, 128 ticks -> right hit: col 576, row 368, dir left, dx 3; next tick col 573.
REQ-030 WIN_SCORE=2, two left misses -> state OVER, game_over=1, right_score=2; serve -> scores 0, WAIT, game_over=0.
REQ-031 reset asserted mid-PLAY together with frame_tick and serve -> next cycle shows all REQ-026 values; no motion.
REQ-032 frame_tick and serve in the same WAIT cycle -> PLAY, ball still at (240, 320).

Source files
------------

// File: rtl/pong_ball_engine.sv
// Pong ball engine: a serve/rally/score FSM that moves the ball once per frame,
// bounces it off paddles and walls, and keeps the match score.
module pong_ball_engine #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int PAD_HALF  = 24,
  parameter int LP_COL    = 64,
  parameter int RP_COL    = 576,
  parameter int DX0       = 2,
  parameter int DX_MAX    = 8,
  parameter int WIN_SCORE = 9
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [8:0] lp_row,
  input  logic [8:0] rp_row,
  output logic [8:0] ball_row,
  output logic [9:0] ball_col,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       point_l,
  output logic       point_r,
  output logic       game_over,
  output logic [1:0] state
);
  typedef enum logic [1:0] {S_WAIT = 2'd0, S_PLAY = 2'd1, S_POINT = 2'd2, S_OVER = 2'd3} state_t;

  localparam logic [9:0] COL_C   = 10'(H_ACTIVE / 2);
  localparam logic [8:0] ROW_C   = 9'(V_ACTIVE / 2);
  localparam logic [8:0] ROW_MAX = 9'(V_ACTIVE - 1);
  localparam logic [9:0] COL_MAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0] LP      = 10'(LP_COL);
  localparam logic [9:0] RP      = 10'(RP_COL);
  localparam logic [9:0] DX_0    = 10'(DX0);
  localparam logic [9:0] DX_M    = 10'(DX_MAX);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic signed [11:0] PAD = 12'(PAD_HALF);

  state_t      state_q, state_d;
  logic [8:0]  row_q, row_d;
  logic [9:0]  col_q, col_d, dx_q, dx_d;
  logic        dir_r_q, dir_r_d, dy_dn_q, dy_dn_d;
  logic [3:0]  lsc_q, lsc_d, rsc_q, rsc_d;
  logic        pl_q, pl_d, pr_q, pr_d, go_q, go_d;

  logic signed [11:0] row_s, lp_s, rp_s;
  logic        in_lp, in_rp, hit_l, hit_r, miss_l, miss_r, dy_nx;
  logic [8:0]  row_nx;
  logic [9:0]  dx_inc;
  logic [3:0]  sc_nx;

  // Paddle window compare is done signed and wide so lp_row-PAD_HALF never wraps.
  always_comb begin
    row_s  = signed'({3'b000, row_q});
    lp_s   = signed'({3'b000, lp_row});
    rp_s   = signed'({3'b000, rp_row});
    in_lp  = (row_s >= lp_s - PAD) && (row_s <= lp_s + PAD);
    in_rp  = (row_s >= rp_s - PAD) && (row_s <= rp_s + PAD);
    hit_l  = !dir_r_q && (col_q > LP) && (col_q - dx_q <= LP) && in_lp;
    hit_r  = dir_r_q && (col_q < RP) && (col_q + dx_q >= RP) && in_rp;
    miss_l = !dir_r_q && (col_q <= dx_q);
    miss_r = dir_r_q && (col_q + dx_q >= COL_MAX);
    row_nx = dy_dn_q ? row_q + 9'd1 : row_q - 9'd1;
    dy_nx  = (row_nx == 9'd0 || row_nx == ROW_MAX) ? ~dy_dn_q : dy_dn_q;
    dx_inc = (dx_q >= DX_M) ? DX_M : dx_q + 10'd1;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dx_d    = dx_q;
    dir_r_d = dir_r_q;
    dy_dn_d = dy_dn_q;
    lsc_d   = lsc_q;
    rsc_d   = rsc_q;
    pl_d    = 1'b0;
    pr_d    = 1'b0;
    sc_nx   = 4'd0;
    case (state_q)
      S_WAIT: if (serve) state_d = S_PLAY;
      S_PLAY: if (frame_tick) begin
        if (hit_l || hit_r) begin
          col_d   = hit_l ? LP : RP;
          dir_r_d = hit_l;
          dx_d    = dx_inc;
          row_d   = row_nx;
          dy_dn_d = dy_nx;
        end else if (miss_l || miss_r) begin
          state_d = S_POINT;
          pl_d    = miss_r;
          pr_d    = miss_l;
        end else begin
          col_d   = dir_r_q ? col_q + dx_q : col_q - dx_q;
          row_d   = row_nx;
          dy_dn_d = dy_nx;
        end
      end
      S_POINT: begin
        // The serve goes toward whoever just lost the point.
        if (pl_q) begin
          sc_nx   = (lsc_q < WIN) ? lsc_q + 4'd1 : lsc_q;
          lsc_d   = sc_nx;
          dir_r_d = 1'b1;
        end else begin
          sc_nx   = (rsc_q < WIN) ? rsc_q + 4'd1 : rsc_q;
          rsc_d   = sc_nx;
          dir_r_d = 1'b0;
        end
        state_d = (sc_nx == WIN) ? S_OVER : S_WAIT;
        row_d   = ROW_C;
        col_d   = COL_C;
        dx_d    = DX_0;
        dy_dn_d = 1'b1;
      end
      S_OVER: if (serve) begin
        lsc_d   = 4'd0;
        rsc_d   = 4'd0;
        dir_r_d = 1'b1;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
    go_d = (state_d == S_OVER);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_WAIT;
      row_q   <= ROW_C;
      col_q   <= COL_C;
      dx_q    <= DX_0;
      dir_r_q <= 1'b1;
      dy_dn_q <= 1'b1;
      lsc_q   <= 4'd0;
      rsc_q   <= 4'd0;
      pl_q    <= 1'b0;
      pr_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dx_q    <= dx_d;
      dir_r_q <= dir_r_d;
      dy_dn_q <= dy_dn_d;
      lsc_q   <= lsc_d;
      rsc_q   <= rsc_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      go_q    <= go_d;
    end
  end

  assign ball_row    = row_q;
  assign ball_col    = col_q;
  assign left_score  = lsc_q;
  assign right_score = rsc_q;
  assign point_l     = pl_q;
  assign point_r     = pr_q;
  assign game_over   = go_q;
  assign state       = state_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed scenarios plus randomized play, checked each cycle against a
// rule-level reference model of the ball engine.
module tb_pong_ball_engine;
  localparam int H = 640, V = 480, PAD = 24, LPC = 64, RPC = 576, DX0 = 2, DXM = 8, WIN = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1, frame_tick = 1'b0, serve = 1'b0;
  logic [8:0] lp_row = 9'd0, rp_row = 9'd0;
  logic [8:0] ball_row;
  logic [9:0] ball_col;
  logic [3:0] left_score, right_score;
  logic       point_l, point_r, game_over;
  logic [1:0] state;

  pong_ball_engine #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PAD_HALF(PAD), .LP_COL(LPC), .RP_COL(RPC),
    .DX0(DX0), .DX_MAX(DXM), .WIN_SCORE(WIN)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick), .serve(serve),
    .lp_row(lp_row), .rp_row(rp_row), .ball_row(ball_row), .ball_col(ball_col),
    .left_score(left_score), .right_score(right_score), .point_l(point_l),
    .point_r(point_r), .game_over(game_over), .state(state)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0, n_err = 0;
  // model: state 0 wait, 1 play, 2 point, 3 over; dir/dy are +1/-1
  int m_st, m_row, m_col, m_dx, m_dir, m_dy, m_ls, m_rs, m_pl, m_pr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_row = V / 2; m_col = H / 2; m_dx = DX0; m_dir = 1; m_dy = 1;
    m_ls = 0; m_rs = 0; m_pl = 0; m_pr = 0;
  endtask

  task automatic m_vert();
    m_row = m_row + m_dy;
    if (m_row == 0 || m_row == V - 1) m_dy = -m_dy;
  endtask

  task automatic m_step(input bit rst, input bit ft, input bit sv);
    int pad_c, scorer_l;
    if (rst) begin m_reset(); return; end
    scorer_l = m_pl;
    m_pl = 0; m_pr = 0;
    case (m_st)
      0: if (sv) m_st = 1;
      1: if (ft) begin
        pad_c = (m_dir > 0) ? int'(rp_row) : int'(lp_row);
        if (m_dir > 0 && m_col + m_dx >= RPC && m_col < RPC &&
            m_row >= pad_c - PAD && m_row <= pad_c + PAD) begin
          m_col = RPC; m_dir = -1; m_dx = (m_dx + 1 > DXM) ? DXM : m_dx + 1; m_vert();
        end else if (m_dir < 0 && m_col - m_dx <= LPC && m_col > LPC &&
                     m_row >= pad_c - PAD && m_row <= pad_c + PAD) begin
          m_col = LPC; m_dir = 1; m_dx = (m_dx + 1 > DXM) ? DXM : m_dx + 1; m_vert();
        end else if (m_dir < 0 && m_col <= m_dx) begin
          m_st = 2; m_pr = 1;
        end else if (m_dir > 0 && m_col + m_dx >= H - 1) begin
          m_st = 2; m_pl = 1;
        end else begin
          m_col = m_col + m_dir * m_dx; m_vert();
        end
      end
      2: begin
        if (scorer_l != 0) begin m_ls++; m_dir = 1; end
        else begin m_rs++; m_dir = -1; end
        m_st = (m_ls == WIN || m_rs == WIN) ? 3 : 0;
        m_row = V / 2; m_col = H / 2; m_dx = DX0; m_dy = 1;
      end
      default: if (sv) begin m_ls = 0; m_rs = 0; m_dir = 1; m_st = 0; end
    endcase
  endtask

  task automatic cyc(input bit rst, input bit ft, input bit sv);
    reset = rst; frame_tick = ft; serve = sv;
    @(posedge CLOCK_50);
    m_step(rst, ft, sv);
    #1;
    chk("state", int'(state), m_st);
    chk("row", int'(ball_row), m_row);
    chk("col", int'(ball_col), m_col);
    chk("lscore", int'(left_score), m_ls);
    chk("rscore", int'(right_score), m_rs);
    chk("point_l", int'(point_l), m_pl);
    chk("point_r", int'(point_r), m_pr);
    chk("game_over", int'(game_over), (m_st == 3) ? 1 : 0);
    reset = 1'b0; frame_tick = 1'b0; serve = 1'b0;
  endtask

  function automatic logic [8:0] near(input int r);
    int t;
    t = r + int'($urandom_range(0, 60)) - 30;
    if (t < 0) t = 0;
    if (t > 511) t = 511;
    return 9'(t);
  endfunction

  initial begin
    int guard;
    m_reset();
    // reset state and first serve tick
    cyc(1, 0, 0);
    chk("rst_row", int'(ball_row), 240);
    chk("rst_col", int'(ball_col), 320);
    chk("rst_state", int'(state), 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("serve_row", int'(ball_row), 241);
    chk("serve_col", int'(ball_col), 322);
    chk("serve_state", int'(state), 1);

    // right miss at column 638
    cyc(1, 0, 0); lp_row = 9'd0; rp_row = 9'd0;
    cyc(0, 0, 1);
    for (int i = 0; i < 160; i++) cyc(0, 1, 0);
    chk("miss_col", int'(ball_col), 638);
    chk("miss_pl", int'(point_l), 1);
    chk("miss_state", int'(state), 2);
    cyc(0, 0, 0);
    chk("pt_pl_gone", int'(point_l), 0);
    chk("pt_lscore", int'(left_score), 1);
    chk("pt_row", int'(ball_row), 240);
    chk("pt_col", int'(ball_col), 320);
    chk("pt_state", int'(state), 0);
    cyc(0, 0, 1); cyc(0, 1, 0);
    chk("pt_dir_right", int'(ball_col), 322);

    // right paddle hit
    cyc(1, 0, 0); rp_row = 9'd367;
    cyc(0, 0, 1);
    for (int i = 0; i < 128; i++) cyc(0, 1, 0);
    chk("hit_col", int'(ball_col), 576);
    chk("hit_row", int'(ball_row), 368);
    cyc(0, 1, 0);
    chk("hit_next_col", int'(ball_col), 573);

    // match to WIN_SCORE, then restart
    cyc(1, 0, 0); rp_row = 9'd367; lp_row = 9'd0;
    guard = 0;
    while (m_st != 3 && guard < 3000) begin cyc(0, 1, m_st == 0); guard++; end
    chk("over_state", int'(state), 3);
    chk("over_go", int'(game_over), 1);
    chk("over_rscore", int'(right_score), 2);
    cyc(0, 1, 0);
    chk("over_park_col", int'(ball_col), 320);
    cyc(0, 0, 1);
    chk("restart_state", int'(state), 0);
    chk("restart_rscore", int'(right_score), 0);
    chk("restart_go", int'(game_over), 0);

    // reset mid-play with tick and serve
    cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    cyc(1, 1, 1);
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_row", int'(ball_row), 240);
    chk("mid_rst_col", int'(ball_col), 320);

    // tick and serve in the same WAIT cycle
    cyc(0, 1, 1);
    chk("ws_state", int'(state), 1);
    chk("ws_row", int'(ball_row), 240);
    chk("ws_col", int'(ball_col), 320);

    // randomized play
    for (int i = 0; i < 12000; i++) begin
      lp_row = ($urandom_range(0, 3) != 0) ? near(m_row) : 9'($urandom_range(0, 511));
      rp_row = ($urandom_range(0, 3) != 0) ? near(m_row) : 9'($urandom_range(0, 511));
      cyc($urandom_range(0, 1999) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
